// File: rtl/adder_421_stream_ctrl.sv
// Ready/valid shell around the pipelined 4:1 adder: credit-based issue
// and an in-order show-ahead result FIFO.
module adder_421_stream_ctrl #(
  parameter int IN_WIDTH   = 256,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int SW = IN_WIDTH + 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_WIDTH-1:0] s_a,
  input  logic [IN_WIDTH-1:0] s_b,
  input  logic [IN_WIDTH-1:0] s_c,
  input  logic [IN_WIDTH-1:0] s_d,
  output logic                add_in_valid,
  output logic [IN_WIDTH-1:0] add_a,
  output logic [IN_WIDTH-1:0] add_b,
  output logic [IN_WIDTH-1:0] add_c,
  output logic [IN_WIDTH-1:0] add_d,
  input  logic [SW-1:0]       add_s,
  input  logic                add_out_valid,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [SW-1:0]       m_sum,
  output logic [CW-1:0]       inflight,
  output logic                err
);

  if (LATENCY < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("adder_421_stream_ctrl: bad LATENCY or FIFO_DEPTH");
  end

  localparam logic [CW:0]   DEPTH_S = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [SW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight_q;
  logic          err_q;

  logic [CW:0] credit_used;
  logic        issue;
  logic        pop;
  logic        full;
  logic        drop;
  logic        push;

  // Credits cover both the adder pipe and the FIFO, so a result
  // always has a slot by the time it leaves the adder.
  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign s_ready     = credit_used < DEPTH_S;

  assign issue        = s_valid & s_ready;
  assign add_in_valid = issue;
  assign add_a        = s_a;
  assign add_b        = s_b;
  assign add_c        = s_c;
  assign add_d        = s_d;

  assign m_valid = fifo_count != '0;
  assign m_sum   = mem[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign full    = fifo_count == DEPTH_C;

  // A result with nothing outstanding, or with no room, is a protocol
  // violation: flag it and leave all state untouched.
  assign drop = add_out_valid &
                ((inflight_q == '0) | (full & ~pop));
  assign push = add_out_valid & ~drop;

  assign inflight = inflight_q;
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= add_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fifo_count <= '0;
    end else begin
      unique case (1'b1)
        push & ~pop: fifo_count <= fifo_count + CNT_ONE;
        pop & ~push: fifo_count <= fifo_count - CNT_ONE;
        default:     fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inflight_q <= '0;
    end else begin
      unique case (1'b1)
        issue & ~push: inflight_q <= inflight_q + CNT_ONE;
        push & ~issue: inflight_q <= inflight_q - CNT_ONE;
        default:       inflight_q <= inflight_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (drop) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_421_stream_ctrl.sv
// Bench for adder_421_stream_ctrl with a behavioural 4-stage adder
// and a queue-based model of the credit shell.
module tb_adder_421_stream_ctrl;
  localparam int W   = 16;
  localparam int LAT = 4;
  localparam int DEP = 8;
  localparam int CW  = 4;
  localparam int SW  = W + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_a = '0, s_b = '0, s_c = '0, s_d = '0;
  logic          add_in_valid;
  logic [W-1:0]  add_a, add_b, add_c, add_d;
  logic [SW-1:0] add_s;
  logic          add_out_valid;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [SW-1:0] m_sum;
  logic [CW-1:0] inflight;
  logic          err;

  always #5 clk = ~clk;

  adder_421_stream_ctrl #(
    .IN_WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .s_c(s_c), .s_d(s_d),
    .add_in_valid(add_in_valid),
    .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
    .add_s(add_s), .add_out_valid(add_out_valid),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum),
    .inflight(inflight), .err(err)
  );

  // Stand-in adder: LAT register stages, shares resetn
  logic [SW-1:0] ps [LAT];
  logic          pv [LAT];
  logic          force_ov = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= add_in_valid;
      ps[0] <= SW'(add_a) + SW'(add_b) + SW'(add_c) + SW'(add_d);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
      end
    end
  end

  assign add_out_valid = pv[LAT-1] | force_ov;
  assign add_s         = ps[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: q_inf holds sums issued but not yet returned, q_fifo holds
  // sums awaiting the consumer, both in issue order.
  logic [SW-1:0] q_inf [$];
  logic [SW-1:0] q_fifo [$];
  bit            m_err = 1'b0;
  bit            armed = 1'b0;

  always @(negedge clk) begin
    bit e_rdy, e_mv, e_iv, pop, push_ok;
    e_rdy = (q_inf.size() + q_fifo.size()) < DEP;
    e_mv  = q_fifo.size() != 0;
    e_iv  = s_valid & e_rdy;
    if (armed) begin
      chk("s_ready", 64'(s_ready), 64'(e_rdy));
      chk("m_valid", 64'(m_valid), 64'(e_mv));
      chk("add_in_valid", 64'(add_in_valid), 64'(e_iv));
      chk("inflight", 64'(inflight), 64'(q_inf.size()));
      chk("err", 64'(err), 64'(m_err));
      if (e_mv) chk("m_sum", 64'(m_sum), 64'(q_fifo[0]));
      if (e_iv) chk("add_ops", 64'({add_a, add_b, add_c, add_d}),
                    64'({s_a, s_b, s_c, s_d}));
    end
    if (!resetn) begin
      q_inf.delete();
      q_fifo.delete();
      m_err = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      pop     = e_mv & m_ready;
      push_ok = add_out_valid && q_inf.size() != 0 &&
                (q_fifo.size() < DEP || pop);
      if (add_out_valid && !push_ok) m_err = 1'b1;
      if (pop) void'(q_fifo.pop_front());
      if (push_ok) q_fifo.push_back(q_inf.pop_front());
      if (e_iv) q_inf.push_back(SW'(s_a) + SW'(s_b) + SW'(s_c) + SW'(s_d));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    s_a = W'($urandom);
    s_b = W'($urandom);
    s_c = W'($urandom);
    s_d = W'($urandom);
  endtask

  int            nacc, npop, first, nv, lowcnt, ncyc;
  bit            acc, seen;
  logic [SW-1:0] got;

  initial begin
    repeat (3) cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk("t1_s_ready", 64'(s_ready), 64'd1);
    chk("t1_m_valid", 64'(m_valid), 64'd0);
    chk("t1_add_in_valid", 64'(add_in_valid), 64'd0);
    chk("t1_inflight", 64'(inflight), 64'd0);
    chk("t1_err", 64'(err), 64'd0);

    // single op, latency to m_valid
    cyc();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_a = 16'd1; s_b = 16'd2; s_c = 16'd3; s_d = 16'd4;
    cyc();
    s_valid = 1'b0;
    first = 0; nv = 0; got = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_valid) begin
        nv++;
        if (first == 0) begin
          first = k;
          got = m_sum;
        end
      end
      cyc();
    end
    chk("t2_latency", 64'(first), 64'd5);
    chk("t2_count", 64'(nv), 64'd1);
    chk("t2_sum", 64'(got), 64'd10);

    // 200 back-to-back ops
    nacc = 0; npop = 0; lowcnt = 0; ncyc = 0;
    s_valid = 1'b1;
    rnd_ops();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      acc = s_valid & s_ready;
      if (acc) nacc++;
      if (k >= 5 && !s_ready) lowcnt++;
      if (m_valid & m_ready) npop++;
      ncyc++;
      cyc();
      if (acc) rnd_ops();
      if (nacc == 200) break;
    end
    s_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_valid & m_ready) npop++;
      cyc();
    end
    chk("t3_accepted", 64'(nacc), 64'd200);
    chk("t3_cycles", 64'(ncyc), 64'd200);
    chk("t3_ready_low", 64'(lowcnt), 64'd0);
    chk("t3_pops", 64'(npop), 64'd200);

    // fill with consumer stalled
    m_ready = 1'b0;
    s_valid = 1'b1;
    rnd_ops();
    nacc = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      acc = s_valid & s_ready;
      if (acc) nacc++;
      cyc();
      if (acc) rnd_ops();
    end
    s_valid = 1'b0;
    repeat (6) cyc();
    @(negedge clk);
    chk("t4_accepted", 64'(nacc), 64'd8);
    chk("t4_ready_full", 64'(s_ready), 64'd0);
    cyc();
    m_ready = 1'b1;
    npop = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) chk("t4_ready_at_pop", 64'(s_ready), 64'd0);
      if (k == 1) chk("t4_ready_after_pop", 64'(s_ready), 64'd1);
      if (m_valid) npop++;
      cyc();
    end
    chk("t4_pops", 64'(npop), 64'd8);

    // maximum operands
    s_valid = 1'b1;
    s_a = 16'hFFFF; s_b = 16'hFFFF; s_c = 16'hFFFF; s_d = 16'hFFFF;
    cyc();
    s_valid = 1'b0;
    seen = 1'b0; got = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_valid && !seen) begin
        seen = 1'b1;
        got = m_sum;
      end
      cyc();
    end
    chk("t5_max_seen", 64'(seen), 64'd1);
    chk("t5_max_sum", 64'(got), 64'h3FFFC);

    // random consumer stalls across several pointer wraps
    nacc = 0; npop = 0;
    s_valid = 1'b1;
    rnd_ops();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      acc = s_valid & s_ready;
      if (acc) nacc++;
      if (m_valid & m_ready) npop++;
      cyc();
      if (acc) rnd_ops();
      s_valid = $urandom_range(0, 3) != 0;
      m_ready = $urandom_range(0, 1) != 0;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (m_valid & m_ready) npop++;
      cyc();
    end
    chk("t5_no_loss", 64'(npop), 64'(nacc));
    chk("t5_wraps", 64'(npop >= 3 * DEP), 64'd1);

    // reset with 3 in flight and 5 queued
    m_ready = 1'b0;
    cyc();
    s_valid = 1'b1;
    rnd_ops();
    nacc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (s_valid & s_ready) nacc++;
      cyc();
      rnd_ops();
      if (k == 7) s_valid = 1'b0;
    end
    cyc();
    resetn = 1'b0;
    @(negedge clk);
    chk("t6_pre_accepted", 64'(nacc), 64'd8);
    chk("t6_pre_inflight", 64'(inflight), 64'd3);
    chk("t6_pre_m_valid", 64'(m_valid), 64'd1);
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_rst_inflight", 64'(inflight), 64'd0);
    chk("t6_rst_m_valid", 64'(m_valid), 64'd0);
    chk("t6_rst_s_ready", 64'(s_ready), 64'd1);
    chk("t6_rst_err", 64'(err), 64'd0);
    repeat (2) cyc();
    force_ov = 1'b1;
    cyc();
    force_ov = 1'b0;
    @(negedge clk);
    chk("t6_err_set", 64'(err), 64'd1);
    chk("t6_err_inflight", 64'(inflight), 64'd0);
    chk("t6_err_m_valid", 64'(m_valid), 64'd0);
    repeat (5) cyc();
    @(negedge clk);
    chk("t6_err_sticky", 64'(err), 64'd1);
    cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    @(negedge clk);
    chk("t6_err_cleared", 64'(err), 64'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
